// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch/decode constants and the IF/ID entry type
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP_INST = 32'h0;
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } if_entry_t;
endpackage

// File: rtl/if_queue_mem.sv
// if_queue_mem: DEPTH x W register array; ports clk, i_we/i_waddr/i_wdata write, i_raddr -> o_rdata async read
module if_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: flushable fetch->decode FIFO; in_valid/in_pc/in_inst/in_ready push side, out_valid/out_pc/out_inst/out_ready pop side, flush, count, clk, rst (async active-low)
module if_id_queue
  import cpu_pkg::NOP_INST;
#(
  parameter int DEPTH = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_inst,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  input  logic              out_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);
  localparam int PW = CNT_W - 1;
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_push, w_pop;
  logic [2*DATA_W-1:0] w_rdata;
  assign in_ready  = r_count != CNT_W'(DEPTH);
  assign out_valid = r_count != '0;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign count     = r_count;
  assign out_pc    = out_valid ? w_rdata[2*DATA_W-1:DATA_W] : '0;
  assign out_inst  = out_valid ? w_rdata[DATA_W-1:0] : DATA_W'(NOP_INST);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_push);
      r_rptr  <= r_rptr + PW'(w_pop);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  if_queue_mem #(.DEPTH(DEPTH), .W(2*DATA_W), .AW(PW)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata ({in_pc, in_inst}),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue
module tb_if_id_queue;
  logic        clk = 0;
  logic        rst = 0;
  logic        in_valid = 0;
  logic [31:0] in_pc = 0;
  logic [31:0] in_inst = 0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready = 0;
  logic        flush = 0;
  logic [2:0]  count;
  int          n_checks = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  if_id_queue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1;
    in_pc    = pc;
    in_inst  = inst;
    tick();
    in_valid = 0;
  endtask
  initial begin
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    @(negedge clk);
    rst = 1;
    tick();
    push(32'h0, 32'h20010005);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_pc", 64'(out_pc), 64'h0);
    chk("t1_inst", 64'(out_inst), 64'h20010005);
    chk("t1_count", 64'(count), 64'd1);
    flush = 1;
    tick();
    flush = 0;
    chk("t1_flush_count", 64'(count), 64'd0);
    for (int i = 0; i < 4; i++) push(32'(4*i), 32'(32'h100 + i));
    chk("t2_full_count", 64'(count), 64'd4);
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    push(32'h10, 32'h110);
    chk("t2_ignored_count", 64'(count), 64'd4);
    chk("t2_head_kept", 64'(out_pc), 64'h0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_pop_pc", 64'(out_pc), 64'(4*i));
      chk("t2_pop_inst", 64'(out_inst), 64'(32'h100 + i));
      tick();
    end
    out_ready = 0;
    chk("t2_empty_valid", 64'(out_valid), 64'd0);
    chk("t2_empty_count", 64'(count), 64'd0);
    in_valid  = 1;
    out_ready = 1;
    in_pc     = 32'h100;
    in_inst   = 32'h1000;
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("t3_stream_pc", 64'(out_pc), 64'(32'h100 + 4*k));
      chk("t3_stream_inst", 64'(out_inst), 64'(32'h1000 + k));
      chk("t3_stream_count", 64'(count), 64'd1);
      in_pc   = 32'(32'h100 + 4*(k+1));
      in_inst = 32'(32'h1000 + k + 1);
      tick();
    end
    in_valid = 0;
    tick();
    out_ready = 0;
    chk("t3_drained", 64'(count), 64'd0);
    push(32'h20, 32'h200);
    push(32'h24, 32'h204);
    push(32'h28, 32'h208);
    chk("t4_count3", 64'(count), 64'd3);
    flush     = 1;
    in_valid  = 1;
    in_pc     = 32'h40;
    in_inst   = 32'h400;
    out_ready = 1;
    tick();
    flush     = 0;
    in_valid  = 0;
    out_ready = 0;
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_valid", 64'(out_valid), 64'd0);
    chk("t4_pc", 64'(out_pc), 64'd0);
    chk("t4_inst", 64'(out_inst), 64'd0);
    chk("t4_ready", 64'(in_ready), 64'd1);
    tick();
    chk("t4_no_0x40", 64'(out_valid), 64'd0);
    push(32'h50, 32'h500);
    push(32'h54, 32'h504);
    chk("t5_count2", 64'(count), 64'd2);
    #3 rst = 0;
    #1;
    chk("t5_async_count", 64'(count), 64'd0);
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    #2 rst = 1;
    push(32'h8, 32'h88);
    chk("t5_head_valid", 64'(out_valid), 64'd1);
    chk("t5_head_pc", 64'(out_pc), 64'h8);
    chk("t5_head_count", 64'(count), 64'd1);
    out_ready = 1;
    tick();
    out_ready = 0;
    for (int i = 0; i < 4; i++) push(32'(32'h60 + 4*i), 32'(32'h600 + i));
    chk("t6_full_ready", 64'(in_ready), 64'd0);
    out_ready = 1;
    in_valid  = 1;
    in_pc     = 32'h70;
    in_inst   = 32'h604;
    tick();
    out_ready = 0;
    chk("t6_pop_only_count", 64'(count), 64'd3);
    chk("t6_ready_back", 64'(in_ready), 64'd1);
    chk("t6_head", 64'(out_pc), 64'h64);
    tick();
    in_valid = 0;
    chk("t6_push_count", 64'(count), 64'd4);
    out_ready = 1;
    for (int i = 1; i < 5; i++) begin
      chk("t6_order", 64'(out_pc), 64'(32'h60 + 4*i));
      tick();
    end
    out_ready = 0;
    chk("t6_end_empty", 64'(count), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
